// File: rtl/lwe_a_decomposer_pkg.sv
// Shared sizing for the a-vector decomposer and the bootstrapping accumulator.
// Q_WIDTH lives here so both blocks agree on the coefficient modulus.
package lwe_a_decomposer_pkg;

  localparam int DEF_LWE_SIZE = 8;
  localparam int DEF_D_R      = 3;
  localparam int DEF_A_WIDTH  = 4;
  localparam int DEF_Q_WIDTH  = 11;

  // $clog2 that never yields a zero-width vector
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lwe_a_decomposer_if.sv
// Coefficient stream (valid/ready) plus the accumulator a-vector write port.
interface lwe_a_decomposer_if
  import lwe_a_decomposer_pkg::*;
#(
  parameter int Q_WIDTH = DEF_Q_WIDTH,
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int ADDR_W  = clog2_min1(DEF_LWE_SIZE * DEF_D_R)
);
  logic               a_valid;
  logic               a_ready;
  logic [Q_WIDTH-1:0] a_data;
  logic               load_a;
  logic [ADDR_W-1:0]  write_addr_a;
  logic [A_WIDTH-1:0] data_a;

  modport master (
    output a_valid, a_data,
    input  a_ready, load_a, write_addr_a, data_a
  );

  modport slave (
    input  a_valid, a_data,
    output a_ready, load_a, write_addr_a, data_a
  );
endinterface

// File: rtl/lwe_a_decomposer.sv
// Accepts LWE mask coefficients, optionally negates them mod q, and writes their
// base-2^A_WIDTH digits LSB-first into the accumulator a-vector memory.
module lwe_a_decomposer
  import lwe_a_decomposer_pkg::*;
#(
  parameter int LWE_SIZE = DEF_LWE_SIZE,
  parameter int D_R      = DEF_D_R,
  parameter int A_WIDTH  = DEF_A_WIDTH,
  parameter int Q_WIDTH  = DEF_Q_WIDTH,
  parameter int NEGATE   = 1,
  parameter int ADDR_W   = $clog2(LWE_SIZE * D_R)
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  output logic busy,
  output logic done,
  lwe_a_decomposer_if.slave bus
);

  localparam int R_W = D_R * A_WIDTH;
  localparam int I_W = clog2_min1(LWE_SIZE);
  localparam int J_W = clog2_min1(D_R);

  typedef enum logic [1:0] {IDLE, ACCEPT, EMIT, FIN} state_t;

  state_t             state_reg, state_next;
  logic [R_W-1:0]     r_reg;
  logic [I_W-1:0]     i_reg;
  logic [J_W-1:0]     j_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [Q_WIDTH-1:0] coef_in;
  logic               last_digit;
  logic               last_coef;

  // Two's-complement negation truncated to Q_WIDTH is exactly (q - a) mod q.
  assign coef_in    = (NEGATE != 0) ? (Q_WIDTH'(0) - bus.a_data) : bus.a_data;
  assign last_digit = (j_reg == J_W'(D_R - 1));
  assign last_coef  = (i_reg == I_W'(LWE_SIZE - 1));

  always_ff @(posedge clk) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ACCEPT;
      ACCEPT:  if (bus.a_valid) state_next = EMIT;
      EMIT:    if (last_digit) state_next = last_coef ? FIN : ACCEPT;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_reg    <= '0;
      i_reg    <= '0;
      j_reg    <= '0;
      addr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            i_reg    <= '0;
            j_reg    <= '0;
            addr_reg <= '0;
          end
        end
        ACCEPT: begin
          if (bus.a_valid) begin
            r_reg <= R_W'(coef_in);
            j_reg <= '0;
          end
        end
        EMIT: begin
          // Zero-fill from the top as digits are consumed
          r_reg    <= r_reg >> A_WIDTH;
          addr_reg <= addr_reg + ADDR_W'(1);
          if (last_digit) begin
            j_reg <= '0;
            if (!last_coef) i_reg <= i_reg + I_W'(1);
          end else begin
            j_reg <= j_reg + J_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.a_ready      = (state_reg == ACCEPT);
  assign bus.load_a       = (state_reg == EMIT);
  assign bus.write_addr_a = addr_reg;
  assign bus.data_a       = (state_reg == EMIT) ? r_reg[A_WIDTH-1:0] : '0;
  assign busy             = (state_reg == ACCEPT) || (state_reg == EMIT);
  assign done             = (state_reg == FIN);

endmodule

// File: tb/tb_lwe_a_decomposer.sv
// Directed bench: two small instances (NEGATE=0/1) run in lockstep, plus a
// default-parameter instance driven from a golden coefficient table.
module tb_lwe_a_decomposer;
  import lwe_a_decomposer_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  logic start01, start2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lwe_a_decomposer_if #(.Q_WIDTH(11), .A_WIDTH(4), .ADDR_W(3)) if0 ();
  lwe_a_decomposer_if #(.Q_WIDTH(11), .A_WIDTH(4), .ADDR_W(3)) if1 ();
  lwe_a_decomposer_if if2 ();

  lwe_a_decomposer #(.LWE_SIZE(2), .D_R(3), .A_WIDTH(4), .Q_WIDTH(11), .NEGATE(0), .ADDR_W(3)) u0 (
    .clk(clk), .resetn(resetn), .start(start01), .busy(busy0), .done(done0), .bus(if0));
  lwe_a_decomposer #(.LWE_SIZE(2), .D_R(3), .A_WIDTH(4), .Q_WIDTH(11), .NEGATE(1), .ADDR_W(3)) u1 (
    .clk(clk), .resetn(resetn), .start(start01), .busy(busy1), .done(done1), .bus(if1));
  lwe_a_decomposer u2 (
    .clk(clk), .resetn(resetn), .start(start2), .busy(busy2), .done(done2), .bus(if2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural a-vector memories and write-order trackers
  logic [3:0] mem0 [0:7];
  logic [3:0] mem1 [0:7];
  logic [3:0] mem2 [0:31];
  int exp_addr0, exp_addr1, exp_addr2;
  int done_cnt0, done_cnt1, done_cnt2;
  logic prev_load0 = 1'b0;
  logic [2:0] prev_addr0 = '0;

  always @(negedge clk) begin
    if (if0.load_a) begin
      chk("addr0", 32'(if0.write_addr_a), exp_addr0);
      mem0[if0.write_addr_a] = if0.data_a;
      exp_addr0++;
    end
    if (if1.load_a) begin
      chk("addr1", 32'(if1.write_addr_a), exp_addr1);
      mem1[if1.write_addr_a] = if1.data_a;
      exp_addr1++;
    end
    if (if2.load_a) begin
      chk("addr2", 32'(if2.write_addr_a), exp_addr2);
      mem2[if2.write_addr_a] = if2.data_a;
      exp_addr2++;
    end
    if (done0) begin
      done_cnt0++;
      chk("done0_follows_addr5", {28'd0, prev_load0, prev_addr0}, 32'hD);
    end
    if (done1) done_cnt1++;
    if (done2) done_cnt2++;
    prev_load0 = if0.load_a;
    prev_addr0 = if0.write_addr_a;
  end

  task automatic clear_models();
    for (int k = 0; k < 8; k++) begin
      mem0[k] = 'x;
      mem1[k] = 'x;
    end
    exp_addr0 = 0; exp_addr1 = 0;
    done_cnt0 = 0; done_cnt1 = 0;
  endtask

  // Present one coefficient to u0/u1 after `gap` idle cycles; returns at the
  // negedge after the last digit of that coefficient.
  task automatic send01(input logic [10:0] d0, input logic [10:0] d1, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      chk("gap_load0", 32'(if0.load_a), 0);
      @(negedge clk);
    end
    if0.a_valid = 1'b1; if0.a_data = d0;
    if1.a_valid = 1'b1; if1.a_data = d1;
    n = 0;
    while (!if0.a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 20), 1);
    @(negedge clk);
    if0.a_valid = 1'b0; if0.a_data = '0;
    if1.a_valid = 1'b0; if1.a_data = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run01(input logic [10:0] d0a, input logic [10:0] d0b,
                       input logic [10:0] d1a, input logic [10:0] d1b,
                       input logic [23:0] exp0, input logic [23:0] exp1,
                       input int gap, input logic poke_start);
    clear_models();
    // start together with a_valid: nothing may be accepted in IDLE
    start01 = 1'b1;
    if0.a_valid = 1'b1; if0.a_data = 11'h555;
    if1.a_valid = 1'b1; if1.a_data = 11'h555;
    chk("idle_ready", 32'(if0.a_ready), 0);
    @(negedge clk);
    start01 = poke_start;
    if0.a_valid = 1'b0; if1.a_valid = 1'b0;
    chk("start_to_ready", 32'(if0.a_ready), 1);
    chk("busy_after_start", 32'(busy0), 1);
    chk("no_load_after_start", 32'(if0.load_a), 0);
    send01(d0a, d1a, gap);
    start01 = 1'b0;
    send01(d0b, d1b, gap);
    chk("done0_pulse", 32'(done0), 1);
    chk("done1_pulse", 32'(done1), 1);
    chk("busy0_falls", 32'(busy0), 0);
    @(negedge clk);
    chk("done0_single", 32'(done0), 0);
    chk("done_cnt0", done_cnt0, 1);
    chk("done_cnt1", done_cnt1, 1);
    chk("writes0", exp_addr0, 6);
    chk("writes1", exp_addr1, 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("mem0[%0d]", k), 32'(mem0[k]), 32'(exp0[4*k +: 4]));
      chk($sformatf("mem1[%0d]", k), 32'(mem1[k]), 32'(exp1[4*k +: 4]));
    end
    $display("run gap=%0d poke=%0d: u0 done=%0d u1 done=%0d", gap, poke_start, done_cnt0, done_cnt1);
  endtask

  logic [10:0] g2 [8];

  initial begin
    int n, v;
    g2[0] = 11'h000; g2[1] = 11'h001; g2[2] = 11'h400; g2[3] = 11'h7FF;
    g2[4] = 11'h123; g2[5] = 11'h5A3; g2[6] = 11'h080; g2[7] = 11'h3C7;

    // Reset with stimulus pounding on start/a_valid
    resetn = 1'b0;
    start01 = 1'b1; start2 = 1'b1;
    if0.a_valid = 1'b1; if0.a_data = 11'h5A3;
    if1.a_valid = 1'b1; if1.a_data = 11'h001;
    if2.a_valid = 1'b1; if2.a_data = 11'h001;
    repeat (5) @(negedge clk);
    chk("rst_a_ready", 32'(if0.a_ready), 0);
    chk("rst_load_a", 32'(if0.load_a), 0);
    chk("rst_addr", 32'(if0.write_addr_a), 0);
    chk("rst_data", 32'(if0.data_a), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_busy2", 32'(busy2), 0);
    $display("reset checked");
    resetn = 1'b1; start01 = 1'b0; start2 = 1'b0;
    if0.a_valid = 1'b0; if1.a_valid = 1'b0; if2.a_valid = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy0), 0);

    // Plain runs, back-pressure, then start poked while busy
    run01(11'h5A3, 11'h7FF, 11'h001, 11'h000, 24'h7FF5A3, 24'h0007FF, 0, 1'b0);
    run01(11'h5A3, 11'h7FF, 11'h001, 11'h000, 24'h7FF5A3, 24'h0007FF, 4, 1'b0);
    run01(11'h5A3, 11'h7FF, 11'h001, 11'h000, 24'h7FF5A3, 24'h0007FF, 0, 1'b1);

    // Abort after the second digit
    clear_models();
    start01 = 1'b1;
    @(negedge clk);
    start01 = 1'b0;
    if0.a_valid = 1'b1; if0.a_data = 11'h5A3;
    if1.a_valid = 1'b1; if1.a_data = 11'h001;
    @(negedge clk);
    if0.a_valid = 1'b0; if1.a_valid = 1'b0;
    @(negedge clk);
    chk("abort_digit1_addr", 32'(if0.write_addr_a), 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_load", 32'(if0.load_a), 0);
    chk("abort_addr", 32'(if0.write_addr_a), 0);
    chk("abort_data", 32'(if0.data_a), 0);
    chk("abort_busy", 32'(busy0), 0);
    chk("abort_ready", 32'(if0.a_ready), 0);
    chk("abort_load1", 32'(if1.load_a), 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done0", done_cnt0, 0);
    chk("abort_no_done1", done_cnt1, 0);
    $display("abort checked: writes before reset=%0d", exp_addr0);
    run01(11'h5A3, 11'h7FF, 11'h001, 11'h000, 24'h7FF5A3, 24'h0007FF, 0, 1'b0);

    // Default parameters against the golden coefficient table
    for (int k = 0; k < 32; k++) mem2[k] = 'x;
    exp_addr2 = 0; done_cnt2 = 0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if2.a_valid = 1'b1; if2.a_data = g2[i];
      n = 0;
      while (!if2.a_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("ready2_wait", 32'(n < 20), 1);
      @(negedge clk);
      if2.a_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    chk("done2_pulse", 32'(done2), 1);
    @(negedge clk);
    chk("done_cnt2", done_cnt2, 1);
    chk("writes2", exp_addr2, 24);
    for (int i = 0; i < 8; i++) begin
      v = (2048 - int'(g2[i])) % 2048;
      for (int j = 0; j < 3; j++)
        chk($sformatf("mem2[%0d]", 3*i + j), 32'(mem2[3*i + j]), (v >> (4*j)) % 16);
    end
    $display("golden run: writes=%0d done=%0d", exp_addr2, done_cnt2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
